// File: rtl/add_seq_pkg.sv
// Shared types and helpers for the multi-precision add/subtract sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package add_seq_pkg;

  // A counter over a single word still needs one bit to exist.
  localparam int unsigned CNT_W_MIN = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

`ifdef ADD_SEQ_REGIN_EN
  // Each word takes two RUN cycles: load the adder-input registers, then capture the sum.
  typedef enum logic {
    DRIVE,
    SAMPLE
  } phase_t;
`endif

  // Bit offset of word idx inside a packed multi-word operand.
  function automatic int unsigned word_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

  // Word counter width, never narrower than CNT_W_MIN.
  function automatic int unsigned cnt_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : CNT_W_MIN;
  endfunction

endpackage

// File: rtl/add_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one shared WIDTH-bit adder, LS word first, carry held between words.
// Latency: rsp_valid rises WORDS+1 edges counting the accept edge (2*WORDS+1 with ADD_SEQ_REGIN_EN: registered adder inputs).
// Backpressure: rsp_ready low parks the block in DONE with results stable and req_ready low.
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [WIDTH*WORDS-1:0]   req_a,
  input  logic [WIDTH*WORDS-1:0]   req_b,
  input  logic                     req_sub,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH*WORDS-1:0]   rsp_sum,
  output logic                     rsp_cout,
  output logic                     rsp_ovf,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_cin,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_cout
);

  localparam int unsigned   CW   = cnt_width(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, ovf_q;
  logic [WIDTH-1:0] in_a  [WORDS];
  logic [WIDTH-1:0] in_b  [WORDS];
  logic [WIDTH-1:0] a_q   [WORDS];
  logic [WIDTH-1:0] b_q   [WORDS];
  logic [WIDTH-1:0] sum_q [WORDS];
  logic [WIDTH-1:0] cur_a, cur_b;
  logic             accept, run, step, last;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign accept    = req_valid && (state_q == IDLE);
  assign run       = (state_q == RUN);
  assign last      = (cnt_q == LAST);
  assign rsp_cout  = cout_q;
  assign rsp_ovf   = ovf_q;

  for (genvar g = 0; g < WORDS; g++) begin : g_word
    assign in_a[g] = req_a[word_lsb(g, WIDTH) +: WIDTH];
    assign in_b[g] = req_b[word_lsb(g, WIDTH) +: WIDTH];
    assign rsp_sum[word_lsb(g, WIDTH) +: WIDTH] = sum_q[g];
  end

  // Select the operand words the counter currently points at.
  always_comb begin
    cur_a = '0;
    cur_b = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (cnt_q == CW'(i)) begin
        cur_a = a_q[i];
        cur_b = b_q[i];
      end
    end
  end

`ifdef ADD_SEQ_REGIN_EN
  phase_t           phase_q;
  logic [WIDTH-1:0] add_a_q, add_b_q;
  logic             add_cin_q;

  assign step    = run && (phase_q == SAMPLE);
  assign add_a   = add_a_q;
  assign add_b   = add_b_q;
  assign add_cin = add_cin_q;

  // Alternate DRIVE/SAMPLE inside RUN; adder inputs return to zero once the last word is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= DRIVE;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
    end else if (run) begin
      if (phase_q == DRIVE) begin
        phase_q   <= SAMPLE;
        add_a_q   <= cur_a;
        add_b_q   <= cur_b;
        add_cin_q <= carry_q;
      end else begin
        phase_q <= DRIVE;
        if (last) begin
          add_a_q   <= '0;
          add_b_q   <= '0;
          add_cin_q <= 1'b0;
        end
      end
    end
  end
`else
  // Adder inputs are live only in RUN so the shared adder stays quiet otherwise.
  assign step    = run;
  assign add_a   = run ? cur_a : '0;
  assign add_b   = run ? cur_b : '0;
  assign add_cin = run & carry_q;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: accept in IDLE, leave RUN after the last word, wait for the consumer in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = RUN;
      RUN:     if (step && last) state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Word counter, inter-word carry and final flags; subtract starts with carry=1 (two's complement).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      carry_q <= req_sub;
    end else if (step) begin
      carry_q <= add_cout;
      if (last) begin
        cout_q <= add_cout;
        ovf_q  <= (a_q[WORDS-1][WIDTH-1] == b_q[WORDS-1][WIDTH-1]) &&
                  (add_sum[WIDTH-1] != a_q[WORDS-1][WIDTH-1]);
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // Latch operands on accept (B pre-inverted for subtract); capture each word's sum as it is produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        sum_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        if (accept) begin
          a_q[i] <= in_a[i];
          b_q[i] <= in_b[i] ^ {WIDTH{req_sub}};
        end
        if (step && (cnt_q == CW'(i))) sum_q[i] <= add_sum;
      end
    end
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Bench for add_seq_ctrl: a 32-bit (8x4) instance and an 8-bit (8x1) instance, each with a behavioural adder.
// Latency: expectations follow ADD_SEQ_REGIN_EN when it is defined for the build.
// Backpressure: rsp_ready is driven by the scenarios, sometimes held low.
module tb_add_seq_ctrl;

  localparam int W0 = 8;
  localparam int N0 = 4;
  localparam int W1 = 8;
  localparam int N1 = 1;
`ifdef ADD_SEQ_REGIN_EN
  localparam int LAT0 = 2*N0 + 1;
  localparam int LAT1 = 2*N1 + 1;
  localparam int GAP0 = 2*N0 + 2;
`else
  localparam int LAT0 = N0 + 1;
  localparam int LAT1 = N1 + 1;
  localparam int GAP0 = N0 + 2;
`endif

  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic          req_valid = 1'b0, req_ready, req_sub = 1'b0;
  logic [31:0]   req_a = '0, req_b = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_cout, rsp_ovf;
  logic [31:0]   rsp_sum;
  logic [W0-1:0] add_a, add_b, add_sum;
  logic          add_cin, add_cout;

  // 8-bit single-word instance
  logic          req_valid1 = 1'b0, req_ready1, req_sub1 = 1'b0;
  logic [7:0]    req_a1 = '0, req_b1 = '0;
  logic          rsp_valid1, rsp_ready1 = 1'b0, rsp_cout1, rsp_ovf1;
  logic [7:0]    rsp_sum1;
  logic [W1-1:0] add_a1, add_b1, add_sum1;
  logic          add_cin1, add_cout1;

  assign {add_cout, add_sum}   = {1'b0, add_a}  + {1'b0, add_b}  + {{W0{1'b0}}, add_cin};
  assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + {{W1{1'b0}}, add_cin1};

  add_seq_ctrl #(.WIDTH(W0), .WORDS(N0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
  );

  add_seq_ctrl #(.WIDTH(W1), .WORDS(N1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_a(req_a1), .req_b(req_b1), .req_sub(req_sub1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_sum(rsp_sum1), .rsp_cout(rsp_cout1), .rsp_ovf(rsp_ovf1),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1), .add_sum(add_sum1), .add_cout(add_cout1)
  );

  // Golden n-bit add/subtract from integer arithmetic: unsigned carry/borrow and signed range overflow.
  function automatic void golden(input longint unsigned a_in, input longint unsigned b_in, input bit s,
                                 input int n, output longint unsigned sum, output bit co, output bit ov);
    longint unsigned m, a, b;
    longint sa, sb, r;
    m  = (64'd1 << n) - 64'd1;
    a  = a_in & m;
    b  = b_in & m;
    sa = (((a >> (n-1)) & 64'd1) != 0) ? longint'(a) - longint'(m) - 1 : longint'(a);
    sb = (((b >> (n-1)) & 64'd1) != 0) ? longint'(b) - longint'(m) - 1 : longint'(b);
    if (s) begin
      r   = sa - sb;
      sum = (a - b) & m;
      co  = (a >= b);
    end else begin
      r   = sa + sb;
      sum = (a + b) & m;
      co  = ((a + b) > m);
    end
    ov = (r > longint'(m >> 1)) || (r < -longint'(m >> 1) - 1);
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Drive one op into the 32-bit instance; lat counts edges from the accept edge (inclusive) to rsp_valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold,
                        output logic [31:0] sum, output logic co, output logic ov, output int lat);
    int g;
    req_a = a; req_b = b; req_sub = s; req_valid = 1'b1;
    g = 0;
    while (req_ready !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_sub = 1'($urandom_range(0, 1));
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    repeat (hold) begin @(posedge clk); #1; end
    sum = rsp_sum; co = rsp_cout; ov = rsp_ovf;
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  task automatic run_op1(input logic [7:0] a, input logic [7:0] b, input logic s, input int hold,
                         output logic [7:0] sum, output logic co, output logic ov, output int lat);
    int g;
    req_a1 = a; req_b1 = b; req_sub1 = s; req_valid1 = 1'b1;
    g = 0;
    while (req_ready1 !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    req_valid1 = 1'b0; req_a1 = 8'($urandom); req_b1 = 8'($urandom);
    lat = 1;
    while (rsp_valid1 !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    repeat (hold) begin @(posedge clk); #1; end
    sum = rsp_sum1; co = rsp_cout1; ov = rsp_ovf1;
    rsp_ready1 = 1'b1; @(posedge clk); #1; rsp_ready1 = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    for (int k = 0; k < 2; k++) begin
      checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++;
        $display("FAIL reset_hs[%0d]: req_ready=%b rsp_valid=%b expected 1 0", k, req_ready, rsp_valid); end
      checks++; if ({rsp_sum, rsp_cout, rsp_ovf} !== 34'd0) begin errors++;
        $display("FAIL reset_rsp[%0d]: sum=%h cout=%b ovf=%b expected all 0", k, rsp_sum, rsp_cout, rsp_ovf); end
      checks++; if ({add_a, add_b, add_cin} !== 17'd0) begin errors++;
        $display("FAIL reset_adder[%0d]: a=%h b=%h cin=%b expected all 0", k, add_a, add_b, add_cin); end
      checks++; if (req_ready1 !== 1'b1 || rsp_valid1 !== 1'b0) begin errors++;
        $display("FAIL reset_hs1[%0d]: req_ready=%b rsp_valid=%b expected 1 0", k, req_ready1, rsp_valid1); end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++;
      $display("FAIL idle_after_reset: req_ready=%b rsp_valid=%b expected 1 0", req_ready, rsp_valid); end
  endtask

  task automatic test_directed();
    logic [31:0] va[5], vb[5], es[5];
    logic        vs[5], ec[5], ev[5];
    logic [31:0] s;
    logic        co, ov;
    int          lat;
    va = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0005, 32'h1234_5678};
    vb = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0007, 32'h0F0F_0F0F};
    vs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    es = '{32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h2143_6587};
    ec = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    ev = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vs[i], i, s, co, ov, lat);
      checks++; if (s !== es[i]) begin errors++;
        $display("FAIL directed_sum[%0d]: got %h expected %h", i, s, es[i]); end
      checks++; if ({co, ov} !== {ec[i], ev[i]}) begin errors++;
        $display("FAIL directed_flags[%0d]: cout=%b ovf=%b expected %b %b", i, co, ov, ec[i], ev[i]); end
      checks++; if (lat !== LAT0) begin errors++;
        $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, LAT0); end
    end
  endtask

  task automatic test_backpressure();
    int g;
    req_a = 32'h1234_5678; req_b = 32'h0F0F_0F0F; req_sub = 1'b0; req_valid = 1'b1;
    g = 0; while (req_ready !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    req_a = 32'h0000_0010; req_b = 32'h0000_0020;
    g = 0; while (rsp_valid !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
    for (int i = 0; i < 10; i++) begin
      checks++; if (rsp_sum !== 32'h2143_6587 || rsp_valid !== 1'b1) begin errors++;
        $display("FAIL bp_hold[%0d]: sum=%h vld=%b expected 21436587 1", i, rsp_sum, rsp_valid); end
      checks++; if (req_ready !== 1'b0) begin errors++;
        $display("FAIL bp_ready_low[%0d]: req_ready=%b expected 0", i, req_ready); end
      checks++; if ({add_a, add_b, add_cin} !== 17'd0) begin errors++;
        $display("FAIL bp_adder_quiet[%0d]: a=%h b=%h cin=%b expected 0", i, add_a, add_b, add_cin); end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++;
      $display("FAIL bp_no_same_cycle_accept: req_ready=%b rsp_valid=%b expected 1 0", req_ready, rsp_valid); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++;
      $display("FAIL bp_accept_next_cycle: req_ready=%b expected 0", req_ready); end
    g = 0; while (rsp_valid !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
    checks++; if (rsp_sum !== 32'h0000_0030) begin errors++;
      $display("FAIL bp_pending_sum: got %h expected 00000030", rsp_sum); end
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] s;
    logic        co, ov;
    int          lat, g;
    bit          seen;
    req_a = 32'hFFFF_FFFF; req_b = 32'h0000_0001; req_sub = 1'b1; req_valid = 1'b1;
    g = 0; while (req_ready !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++;
      $display("FAIL midrst_hs: req_ready=%b rsp_valid=%b expected 1 0", req_ready, rsp_valid); end
    checks++; if ({rsp_sum, rsp_cout, rsp_ovf} !== 34'd0) begin errors++;
      $display("FAIL midrst_rsp: sum=%h cout=%b ovf=%b expected all 0", rsp_sum, rsp_cout, rsp_ovf); end
    checks++; if ({add_a, add_b, add_cin} !== 17'd0) begin errors++;
      $display("FAIL midrst_adder: a=%h b=%h cin=%b expected all 0", add_a, add_b, add_cin); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (rsp_valid === 1'b1) seen = 1'b1; end
    checks++; if (seen) begin errors++;
      $display("FAIL midrst_no_rsp: rsp_valid seen=1 expected 0"); end
    run_op(32'h0000_0003, 32'h0000_0004, 1'b0, 0, s, co, ov, lat);
    checks++; if (s !== 32'h0000_0007 || co !== 1'b0 || ov !== 1'b0) begin errors++;
      $display("FAIL midrst_next_op: sum=%h cout=%b ovf=%b expected 00000007 0 0", s, co, ov); end
  endtask

  task automatic test_back_to_back();
    int              acc[$];
    int              g;
    longint unsigned gs;
    bit              gc, gv;
    logic [31:0]     a, b;
    a = $urandom; b = $urandom;
    golden(a, b, 1'b0, 32, gs, gc, gv);
    req_a = a; req_b = b; req_sub = 1'b0; req_valid = 1'b1; rsp_ready = 1'b1;
    for (int c = 0; c < 4*GAP0; c++) begin
      if (req_ready === 1'b1) acc.push_back(c);
      if (rsp_valid === 1'b1) begin
        checks++; if (rsp_sum !== gs[31:0] || rsp_cout !== gc || rsp_ovf !== gv) begin errors++;
          $display("FAIL b2b_result@%0d: sum=%h c=%b v=%b expected %h %b %b", c, rsp_sum, rsp_cout, rsp_ovf, gs[31:0], gc, gv); end
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    g = 0; while (req_ready !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
    rsp_ready = 1'b0;
    checks++; if (acc.size() < 3) begin errors++;
      $display("FAIL b2b_accepts: got %0d accepts expected at least 3", acc.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      checks++; if (acc[i] - acc[i-1] !== GAP0) begin errors++;
        $display("FAIL b2b_gap[%0d]: got %0d cycles expected %0d", i, acc[i] - acc[i-1], GAP0); end
    end
  endtask

  task automatic test_random();
    logic [31:0]     a, b, s;
    logic            sub, co, ov;
    int              lat;
    longint unsigned gs;
    bit              gc, gv;
    for (int i = 0; i < 150; i++) begin
      a = pick32(); b = pick32(); sub = 1'($urandom_range(0, 1));
      golden(a, b, sub, 32, gs, gc, gv);
      run_op(a, b, sub, int'($urandom_range(0, 3)), s, co, ov, lat);
      checks++; if (s !== gs[31:0]) begin errors++;
        $display("FAIL rand_sum[%0d]: %h %s %h got %h expected %h", i, a, sub ? "-" : "+", b, s, gs[31:0]); end
      checks++; if (co !== gc || ov !== gv) begin errors++;
        $display("FAIL rand_flags[%0d]: cout=%b ovf=%b expected %b %b", i, co, ov, gc, gv); end
      checks++; if (lat !== LAT0) begin errors++;
        $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, LAT0); end
    end
  endtask

  task automatic test_words1();
    logic [7:0]      a, b, s;
    logic            sub, co, ov;
    int              lat;
    longint unsigned gs;
    bit              gc, gv;
    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom_range(0, 1));
      if (i == 0) begin a = 8'h7F; b = 8'h01; sub = 1'b0; end
      if (i == 1) begin a = 8'h80; b = 8'h01; sub = 1'b1; end
      golden(a, b, sub, 8, gs, gc, gv);
      run_op1(a, b, sub, int'($urandom_range(0, 2)), s, co, ov, lat);
      checks++; if (s !== gs[7:0]) begin errors++;
        $display("FAIL w1_sum[%0d]: %h %s %h got %h expected %h", i, a, sub ? "-" : "+", b, s, gs[7:0]); end
      checks++; if (co !== gc || ov !== gv) begin errors++;
        $display("FAIL w1_flags[%0d]: cout=%b ovf=%b expected %b %b", i, co, ov, gc, gv); end
      checks++; if (lat !== LAT1) begin errors++;
        $display("FAIL w1_latency[%0d]: got %0d expected %0d", i, lat, LAT1); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    test_words1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
